// File: rtl/ofdm_frame_tx.sv
// OFDM TX frame assembler: preamble A/B from ROM, then CP+body per buffered IFFT symbol.
// Latency 2 cycles address->o_valid; i_en=0 freezes FSM and pipeline, o_valid forced low.
module ofdm_frame_tx #(
    parameter int DATA_SIZE = 16,
    parameter int FFT_SIZE  = 64,
    parameter int CP_LEN    = 16,
    parameter int PRE_A_LEN = 160,
    parameter int PRE_B_LEN = 160
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset,
    input  logic                                       i_en,
    input  logic                                       i_start,
    input  logic [7:0]                                 i_num_sym,
    input  logic                                       i_valid,
    input  logic [DATA_SIZE-1:0]                       in_data_i,
    input  logic [DATA_SIZE-1:0]                       in_data_q,
    output logic                                       o_ready,
    output logic [$clog2(PRE_A_LEN+PRE_B_LEN)-1:0]     o_pre_addr,
    input  logic [DATA_SIZE-1:0]                       i_pre_data_i,
    input  logic [DATA_SIZE-1:0]                       i_pre_data_q,
    output logic                                       o_valid,
    output logic [DATA_SIZE-1:0]                       o_data_i,
    output logic [DATA_SIZE-1:0]                       o_data_q,
    output logic                                       o_busy,
    output logic                                       o_frame_done
);
    localparam int PA_W    = $clog2(PRE_A_LEN + PRE_B_LEN);
    localparam int FW      = $clog2(FFT_SIZE);
    localparam int MAX_AB  = (PRE_A_LEN > PRE_B_LEN) ? PRE_A_LEN : PRE_B_LEN;
    localparam int CNT_MAX = (MAX_AB > FFT_SIZE) ? MAX_AB : FFT_SIZE;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int SW      = 2 * DATA_SIZE;

    // DRAIN waits for the last sample to leave the pipeline before DONE.
    typedef enum logic [2:0] {
        S_IDLE, S_PRE_A, S_PRE_B, S_LOAD, S_CP, S_BODY, S_DRAIN, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         sym_q, sym_d;

    logic               issue, rom_src, wr_en;
    logic [PA_W-1:0]    pre_addr;
    logic [FW-1:0]      rd_addr;

    logic [SW-1:0]      mem_q [FFT_SIZE];
    logic [SW-1:0]      buf_rd_q;
    logic [SW-1:0]      rom_hold_q;
    logic [SW-1:0]      s1_dat;
    logic               s1_vld_q, s1_rom_q, s1_fresh_q;
    logic               o_vld_q;
    logic [DATA_SIZE-1:0] o_di_q, o_dq_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sym_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        if (i_en) begin
            case (state_q)
                S_IDLE: if (i_start) begin
                    state_d = S_PRE_A;
                    cnt_d   = '0;
                    sym_d   = i_num_sym;
                end
                S_PRE_A: if (cnt_q == CNT_W'(PRE_A_LEN - 1)) begin
                    state_d = S_PRE_B;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + CNT_W'(1);
                S_PRE_B: if (cnt_q == CNT_W'(PRE_B_LEN - 1)) begin
                    state_d = (sym_q != 8'd0) ? S_LOAD : S_DRAIN;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + CNT_W'(1);
                S_LOAD: if (i_valid) begin
                    if (cnt_q == CNT_W'(FFT_SIZE - 1)) begin
                        state_d = S_CP;
                        cnt_d   = '0;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
                S_CP: if (cnt_q == CNT_W'(CP_LEN - 1)) begin
                    state_d = S_BODY;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + CNT_W'(1);
                S_BODY: if (cnt_q == CNT_W'(FFT_SIZE - 1)) begin
                    sym_d   = sym_q - 8'd1;
                    state_d = (sym_q != 8'd1) ? S_LOAD : S_DRAIN;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + CNT_W'(1);
                S_DRAIN: if (!s1_vld_q) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        issue    = 1'b0;
        rom_src  = 1'b0;
        wr_en    = 1'b0;
        pre_addr = '0;
        rd_addr  = '0;
        case (state_q)
            S_PRE_A: begin
                issue    = i_en;
                rom_src  = 1'b1;
                pre_addr = PA_W'(cnt_q);
            end
            S_PRE_B: begin
                issue    = i_en;
                rom_src  = 1'b1;
                pre_addr = PA_W'(PRE_A_LEN) + PA_W'(cnt_q);
            end
            S_LOAD: wr_en = i_en & i_valid;
            S_CP: begin
                issue   = i_en;
                rd_addr = FW'(FFT_SIZE - CP_LEN) + cnt_q[FW-1:0];
            end
            S_BODY: begin
                issue   = i_en;
                rd_addr = cnt_q[FW-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[cnt_q[FW-1:0]] <= {in_data_i, in_data_q};
        if (issue && !rom_src) buf_rd_q <= mem_q[rd_addr];
    end

    // ROM data is only present for one cycle; if a freeze lands on that cycle it is parked in rom_hold_q.
    assign s1_dat = s1_rom_q ? (s1_fresh_q ? {i_pre_data_i, i_pre_data_q} : rom_hold_q) : buf_rd_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            s1_vld_q   <= 1'b0;
            s1_rom_q   <= 1'b0;
            s1_fresh_q <= 1'b0;
            rom_hold_q <= '0;
            o_vld_q    <= 1'b0;
            o_di_q     <= '0;
            o_dq_q     <= '0;
        end else begin
            s1_fresh_q <= issue;
            if (s1_fresh_q) rom_hold_q <= {i_pre_data_i, i_pre_data_q};
            if (i_en) begin
                s1_vld_q <= issue;
                s1_rom_q <= rom_src;
                o_vld_q  <= s1_vld_q;
                if (s1_vld_q) {o_di_q, o_dq_q} <= s1_dat;
            end
        end
    end

    assign o_pre_addr   = pre_addr;
    assign o_ready      = (state_q == S_LOAD) && i_en;
    assign o_valid      = o_vld_q && i_en;
    assign o_data_i     = o_di_q;
    assign o_data_q     = o_dq_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = (state_q == S_DONE) && i_en;
endmodule
